i2c_cmd_sequencer: RTL

Host-side command front end placed directly upstream of the i2c top block. It queues host transactions in a FIFO and presents them one at a time on the i2c command inputs (en, slave address, read/write, register address, write data). It holds en high for a fixed transaction window, then captures read data from the i2c data output and returns it to the host over a valid/ready response channel.

---
 rtl/i2c_cmd_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Host command front end for the i2c top block: FIFO-queued commands are issued one at a time
// with en held for TXN_CYCLES, and read data is returned on a valid/ready channel.
// Optional feature macro: I2C_SEQ_OVERFLOW_EN adds a sticky overflow flag (ovf) with clear (ovf_clr).
module i2c_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TXN_CYCLES = 1200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_slave_addr,
  input  logic        cmd_rw,
  input  logic [7:0]  cmd_reg_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        busy,
`ifdef I2C_SEQ_OVERFLOW_EN
  input  logic        ovf_clr,
  output logic        ovf,
`endif
  output logic        i2c_en,
  output logic [6:0]  i2c_slave_address,
  output logic        i2c_read_write,
  output logic [7:0]  i2c_register_address,
  output logic [31:0] i2c_data,
  input  logic [31:0] i2c_data_in
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(TXN_CYCLES + 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(TXN_CYCLES - 1);

  typedef struct packed {
    logic [6:0]  slave_addr;
    logic        rw;
    logic [7:0]  reg_addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  cmd_t fifo_mem [FIFO_DEPTH];
  cmd_t cmd_in;
  cmd_t head;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  cmd_t             cur_q, cur_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             full;
  logic             push;
  logic             pop;

  assign cmd_in = '{slave_addr: cmd_slave_addr, rw: cmd_rw, reg_addr: cmd_reg_addr, wdata: cmd_wdata};
  assign full   = (count_q == DEPTH_CNT);
  assign push   = cmd_valid && !full;
  assign head   = fifo_mem[rd_ptr_q];

  // Storage carries no reset: only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= cmd_in;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_d        = en_q;
    cur_d       = cur_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          cur_d   = head;
          en_d    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          en_d = 1'b0;
          // Read data is sampled on the same edge that ends the en window.
          if (cur_q.rw) begin
            rsp_rdata_d = i2c_data_in;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      cur_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      cur_q       <= cur_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef I2C_SEQ_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // A rejected command on the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = (ovf_q && !ovf_clr) || (cmd_valid && full);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign cmd_ready            = !full;
  assign busy                 = (count_q != '0) || (state_q != ST_IDLE);
  assign rsp_valid            = rsp_valid_q;
  assign rsp_rdata            = rsp_rdata_q;
  assign i2c_en               = en_q;
  assign i2c_slave_address    = cur_q.slave_addr;
  assign i2c_read_write       = cur_q.rw;
  assign i2c_register_address = cur_q.reg_addr;
  assign i2c_data             = cur_q.wdata;

endmodule
